// File: rtl/riscv_pkg.sv
// Shared fetch-path types: machine widths and the {pc, instr} record carried to decode.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instruction fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched instructions. The head entry is a register, so the
// outputs to decode are registered. Flush empties the FIFO and overrides push/pop.
module fetch_buf
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [1:0]   count
);

    fetch_entry_t entry0;
    fetch_entry_t entry1;
    logic         pop_ok;

    // A pop only counts against a non-empty buffer.
    assign pop_ok     = pop && (count != 2'd0);
    assign head       = entry0;
    assign head_valid = (count != 2'd0);

    // Storage update: entry0 is always the head, entry1 the one behind it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_entry;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_entry;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= push_entry;
                        count  <= 2'd1;
                    end else if (count == 2'd1) begin
                        entry1 <= push_entry;
                        count  <= 2'd2;
                    end
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end

    // The issue credit rule upstream must never let a push land on a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && !pop_ok && (count == 2'd2)));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the PC, addresses the 1-cycle registered ROM,
// and feeds {pc, instr} to decode through a 2-entry buffer with redirect/flush.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 10
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              redirect_in,
    input  logic [31:0]       redirect_pc_in,
    output logic [ROM_AW-1:0] rom_addr_out,
    input  logic [31:0]       rom_instr_in,
    output logic              instr_valid_out,
    input  logic              instr_ready_in,
    output logic [31:0]       instr_out,
    output logic [31:0]       instr_pc_out
);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic [XLEN-1:0] issued_pc;
    logic            inflight;
    logic            issue;
    logic            pop;
    logic            push;
    logic [1:0]      count;
    logic [2:0]      credit_use;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // A redirect target is issued in the same cycle it arrives.
    assign issued_pc    = redirect_in ? word_align(redirect_pc_in) : fetch_pc;
    assign rom_addr_out = issued_pc[ROM_AW+1:2];

    assign pop = instr_valid_out & instr_ready_in;

    // Entries held plus the one in flight, minus the one leaving, must leave room
    // for the response of anything issued now.
    assign credit_use = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = rst_n_in & (redirect_in | (credit_use < 3'd2));

    // A response belonging to a pre-redirect fetch is dropped.
    assign push             = inflight & ~redirect_in;
    assign push_entry.pc    = inflight_pc;
    assign push_entry.instr = rom_instr_in;

    // PC and in-flight tracking for the single outstanding ROM read.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            fetch_pc    <= word_align(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (issue) begin
            fetch_pc    <= issued_pc + 32'd4;
            inflight    <= 1'b1;
            inflight_pc <= issued_pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_buf u_fetch_buf (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_in),
        .push_entry (push_entry),
        .head       (head),
        .head_valid (instr_valid_out),
        .count      (count)
    );

    assign instr_out    = head.instr;
    assign instr_pc_out = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch with a 1-cycle registered ROM model (rom[i] = A000_0000 | i).
module tb_instr_fetch;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [9:0]  rom_addr;
    logic [31:0] rom_q;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_entry_t sb[$];

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .ROM_AW(10)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .redirect_in     (redirect),
        .redirect_pc_in  (redirect_pc),
        .rom_addr_out    (rom_addr),
        .rom_instr_in    (rom_q),
        .instr_valid_out (valid),
        .instr_ready_in  (ready),
        .instr_out       (instr),
        .instr_pc_out    (instr_pc)
    );

    // ROM model: registered read, data valid the cycle after the address is sampled.
    always_ff @(posedge clk) rom_q <= 32'hA000_0000 | {22'b0, rom_addr};

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'hA000_0000 | {22'b0, pc[11:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = rom_word(e.pc);
            sb.push_back(e);
        end
    endtask

    task automatic monitor();
        fetch_entry_t e;
        if (rst_n && !redirect && valid && ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h with nothing expected", instr_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", instr_pc, e.pc);
                chk("sb_instr", instr, e.instr);
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ready       = 1'b1;

        tbl[0] = '{32'd0, 1'b0, 32'h0};
        tbl[1] = '{32'd1, 1'b0, 32'h0};
        tbl[2] = '{32'd2, 1'b1, 32'h0};
        tbl[3] = '{32'd3, 1'b1, 32'h4};
        tbl[4] = '{32'd4, 1'b1, 32'h8};

        to_pos();
        to_pos();
        at_neg();
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        to_pos();

        // Reset release: first fetch at RESET_PC, valid two cycles later.
        expect_seq(32'h0, 40);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("start_addr", {22'b0, rom_addr}, tbl[i].addr);
            chk("start_valid", {31'b0, valid}, {31'b0, tbl[i].valid});
            if (tbl[i].valid) chk("start_pc", instr_pc, tbl[i].pc);
            to_pos();
        end

        // Stall: head held at 0xC, address frozen.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("stall_valid", {31'b0, valid}, 32'd1);
            chk("stall_pc", instr_pc, 32'hC);
            chk("stall_instr", instr, 32'hA000_0003);
            chk("stall_addr", {22'b0, rom_addr}, 32'd5);
            to_pos();
        end
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("resume_valid", {31'b0, valid}, 32'd1);
            chk("resume_pc", instr_pc, 32'hC + 32'(4 * i));
            to_pos();
        end

        // Redirect to 0x100 while valid.
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        sb.delete();
        expect_seq(32'h100, 40);
        at_neg();
        chk("redir_addr", {22'b0, rom_addr}, 32'h40);
        to_pos();
        redirect = 1'b0;
        at_neg();
        chk("redir_flush_valid", {31'b0, valid}, 32'd0);
        to_pos();
        at_neg();
        chk("redir_valid", {31'b0, valid}, 32'd1);
        chk("redir_pc", instr_pc, 32'h100);
        chk("redir_instr", instr, 32'hA000_0040);
        to_pos();
        for (int i = 0; i < 3; i++) begin
            at_neg();
            to_pos();
        end

        // ROM index wrap: 0xFFC -> 0x1000.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0FFC;
        sb.delete();
        expect_seq(32'h0000_0FFC, 40);
        at_neg();
        chk("wrap_addr_hi", {22'b0, rom_addr}, 32'd1023);
        to_pos();
        redirect = 1'b0;
        at_neg();
        chk("wrap_addr_lo", {22'b0, rom_addr}, 32'd0);
        to_pos();
        at_neg();
        chk("wrap_pc0", instr_pc, 32'h0000_0FFC);
        chk("wrap_instr0", instr, 32'hA000_03FF);
        to_pos();
        at_neg();
        chk("wrap_pc1", instr_pc, 32'h0000_1000);
        chk("wrap_instr1", instr, 32'hA000_0000);
        to_pos();

        // Reset mid-stream with the buffer full.
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            to_pos();
        end
        rst_n = 1'b0;
        sb.delete();
        at_neg();
        to_pos();
        at_neg();
        chk("midrst_valid", {31'b0, valid}, 32'd0);
        chk("midrst_pc", instr_pc, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        to_pos();
        rst_n = 1'b1;
        ready = 1'b1;
        expect_seq(32'h0, 40);
        at_neg();
        chk("rerst_valid0", {31'b0, valid}, 32'd0);
        chk("rerst_addr", {22'b0, rom_addr}, 32'd0);
        to_pos();
        at_neg();
        chk("rerst_valid1", {31'b0, valid}, 32'd0);
        to_pos();
        at_neg();
        chk("rerst_valid2", {31'b0, valid}, 32'd1);
        chk("rerst_pc", instr_pc, 32'h0);
        to_pos();
        for (int i = 0; i < 2; i++) begin
            at_neg();
            to_pos();
        end

        // Redirect to an unaligned target coinciding with a pop.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        sb.delete();
        expect_seq(32'h100, 40);
        at_neg();
        chk("rpop_valid", {31'b0, valid}, 32'd1);
        chk("rpop_addr", {22'b0, rom_addr}, 32'h40);
        to_pos();
        redirect = 1'b0;
        at_neg();
        chk("rpop_flush_valid", {31'b0, valid}, 32'd0);
        to_pos();
        at_neg();
        chk("rpop_pc", instr_pc, 32'h100);
        to_pos();
        for (int i = 0; i < 4; i++) begin
            at_neg();
            to_pos();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
